// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the multiplier writeback stage
//
// Contents:
//   DATA_WIDTH            default writeback byte width
//   state_t               writeback FSM encoding (ST_IDLE, ST_LO, ST_HI)
//   FLG_Z, FLG_N, FLG_V   flag bit offsets above the product field of a FIFO entry
//   FLG_COUNT             number of flag bits stored per entry
package mul_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    // A FIFO entry is {flags, product}; flag bit k lives at entry[2*DATA_WIDTH + k].
    localparam int FLG_Z     = 0;
    localparam int FLG_N     = 1;
    localparam int FLG_V     = 2;
    localparam int FLG_COUNT = 3;

endpackage

// File: rtl/mul_writeback_prod_fifo.sv
// rtl/mul_writeback_prod_fifo.sv - synchronous product FIFO with first-word head output
//
// Parameters:
//   WIDTH   entry width in bits
//   DEPTH   number of entries, power of two, at least 2
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-low reset, empties the FIFO
//   push    write wdata when not full
//   wdata   entry to write
//   pop     discard head when not empty
//   head    oldest entry (combinational read)
//   count   number of stored entries
//   full    count == DEPTH
//   empty   count == 0
module prod_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO refuses a push even when the head is popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head = mem[rd_ptr];

    // Storage is not reset; count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_writeback.sv
// rtl/mul_writeback.sv - serialises signed products onto an 8-bit writeback bus with Z/N/V flags
//
// Parameters:
//   DATA_WIDTH  writeback byte width; products are 2*DATA_WIDTH bits
//   DEPTH       product FIFO entries, power of two, at least 2
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   prod_in      signed product from the multiplier
//   prod_valid   prod_in valid this cycle
//   prod_ready   FIFO can accept a product
//   wb_data      writeback byte (low byte first, then high byte)
//   wb_valid     wb_data valid
//   wb_ready     register file accepts the byte
//   wb_hi        0 = low byte, 1 = high byte
//   wb_last      final byte of a product (same as wb_hi)
//   flag_z       last retired product was zero
//   flag_n       last retired product was negative
//   flag_v       last retired product does not fit in a signed byte
//   flags_valid  one-cycle pulse when the flags update
module mul_writeback #(
    parameter int DATA_WIDTH = mul_pkg::DATA_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] prod_in,
    input  logic                    prod_valid,
    output logic                    prod_ready,
    output logic [DATA_WIDTH-1:0]   wb_data,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic                    wb_hi,
    output logic                    wb_last,
    output logic                    flag_z,
    output logic                    flag_n,
    output logic                    flag_v,
    output logic                    flags_valid
);

    import mul_pkg::*;

    localparam int PW = 2 * DATA_WIDTH;
    localparam int EW = PW + FLG_COUNT;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state;
    logic [EW-1:0]   entry;
    logic [EW-1:0]   head;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [DATA_WIDTH:0] upper;

    // ---------------------------------------------------------------
    // Push side: flags are computed once at entry and travel with it.
    // ---------------------------------------------------------------
    assign prod_ready = !full;
    assign push       = prod_valid && prod_ready;

    // The product fits a signed byte only if its top DATA_WIDTH+1 bits
    // are a pure sign extension.
    assign upper = prod_in[PW-1:DATA_WIDTH-1];

    always_comb begin
        entry                = '0;
        entry[PW-1:0]        = prod_in;
        entry[PW + FLG_Z]    = (prod_in == '0);
        entry[PW + FLG_N]    = prod_in[PW-1];
        entry[PW + FLG_V]    = !((&upper) || !(|upper));
    end

    prod_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (entry),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // ---------------------------------------------------------------
    // Writeback FSM: head stays put until its high byte is accepted.
    // ---------------------------------------------------------------
    assign pop = (state == ST_HI) && wb_ready;

    // Occupancy after this edge's pop, including a same-cycle push, decides
    // whether the next product streams without an idle cycle.
    assign count_after = count - CW'(1) + CW'(push);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wb_valid    <= 1'b0;
            wb_hi       <= 1'b0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_v      <= 1'b0;
            flags_valid <= 1'b0;
        end else begin
            flags_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state    <= ST_LO;
                        wb_valid <= 1'b1;
                        wb_hi    <= 1'b0;
                    end
                end
                ST_LO: begin
                    if (wb_ready) begin
                        state <= ST_HI;
                        wb_hi <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (wb_ready) begin
                        flag_z      <= head[PW + FLG_Z];
                        flag_n      <= head[PW + FLG_N];
                        flag_v      <= head[PW + FLG_V];
                        flags_valid <= 1'b1;
                        wb_hi       <= 1'b0;
                        if (count_after != '0) begin
                            state    <= ST_LO;
                            wb_valid <= 1'b1;
                        end else begin
                            state    <= ST_IDLE;
                            wb_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wb_valid <= 1'b0;
                    wb_hi    <= 1'b0;
                end
            endcase
        end
    end

    assign wb_last = wb_hi;

    // The byte mux follows registered state and a head that only moves on
    // pop, so the byte holds steady under back-pressure.
    always_comb begin
        wb_data = '0;
        if (wb_valid) begin
            wb_data = wb_hi ? head[PW-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_mul_writeback.sv
// tb/tb_mul_writeback.sv - randomized and directed self-checking bench for mul_writeback
module tb_mul_writeback;

    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst;
    logic [2*DW-1:0] prod_in;
    logic            prod_valid;
    logic            prod_ready;
    logic [DW-1:0]   wb_data;
    logic            wb_valid;
    logic            wb_ready;
    logic            wb_hi;
    logic            wb_last;
    logic            flag_z;
    logic            flag_n;
    logic            flag_v;
    logic            flags_valid;

    mul_writeback #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prod_in     (prod_in),
        .prod_valid  (prod_valid),
        .prod_ready  (prod_ready),
        .wb_data     (wb_data),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_hi       (wb_hi),
        .wb_last     (wb_last),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v),
        .flags_valid (flags_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: products accepted but not yet retired, in order.
    logic [2*DW-1:0] pending[$];
    logic            phase;      // 0 = low byte next, 1 = high byte next
    logic            exp_z, exp_n, exp_v;
    logic            flag_due;
    logic            fresh;      // queue was empty and got a product at the last edge
    int              pulses;
    logic            rnd_ready;

    function automatic logic [2:0] ref_flags(input logic [2*DW-1:0] p);
        int s;
        s = int'($signed(p));
        return {(s > 127) || (s < -128), s < 0, s == 0};
    endfunction

    always @(negedge clk) begin
        logic [2*DW-1:0] cur;
        logic [DW-1:0]   exp_byte;
        logic [2:0]      f;
        logic            accept;
        logic            was_empty;
        if (!rst) begin
            expect_eq("rst_wb_valid", wb_valid, 0);
            expect_eq("rst_prod_ready", prod_ready, 1);
            expect_eq("rst_flags_valid", flags_valid, 0);
            pending.delete();
            phase    = 1'b0;
            exp_z    = 1'b0;
            exp_n    = 1'b0;
            exp_v    = 1'b0;
            flag_due = 1'b0;
            fresh    = 1'b0;
        end else begin
            expect_eq("flags_valid", flags_valid, flag_due);
            if (flags_valid) pulses++;
            expect_eq("flag_z", flag_z, exp_z);
            expect_eq("flag_n", flag_n, exp_n);
            expect_eq("flag_v", flag_v, exp_v);
            expect_eq("prod_ready", prod_ready, pending.size() != DEPTH);
            if (pending.size() == 0) begin
                expect_eq("wb_valid_empty", wb_valid, 0);
            end else if (!wb_valid) begin
                expect_eq("wb_gap", {31'd0, fresh}, 1);
            end
            if (wb_valid && pending.size() != 0) begin
                cur      = pending[0];
                exp_byte = phase ? cur[2*DW-1:DW] : cur[DW-1:0];
                expect_eq("wb_data", wb_data, exp_byte);
                expect_eq("wb_hi", wb_hi, phase);
                expect_eq("wb_last", wb_last, phase);
            end
            accept    = prod_valid && (pending.size() != DEPTH);
            was_empty = (pending.size() == 0);
            flag_due  = 1'b0;
            if (wb_valid && wb_ready && pending.size() != 0) begin
                if (phase) begin
                    cur = pending.pop_front();
                    f   = ref_flags(cur);
                    exp_z    = f[0];
                    exp_n    = f[1];
                    exp_v    = f[2];
                    flag_due = 1'b1;
                    phase    = 1'b0;
                end else begin
                    phase = 1'b1;
                end
            end
            if (accept) pending.push_back(prod_in);
            fresh = was_empty && accept;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) wb_ready = 1'($urandom_range(0, 1));
    end

    task automatic drive(input logic [2*DW-1:0] v);
        prod_in    = v;
        prod_valid = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prod_ready) begin
                @(posedge clk);
                #1;
                prod_valid = 1'b0;
                return;
            end
        end
        expect_eq("accept_timeout", prod_ready, 1);
        prod_valid = 1'b0;
    endtask

    task automatic push(input logic [2*DW-1:0] v);
        drive(v);
        wait_accept();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pending.size() == 0 && !wb_valid) break;
        end
        @(negedge clk);
        expect_eq("drain", pending.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wb_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wb_valid) return;
        end
        expect_eq("wb_valid_timeout", wb_valid, 1);
    endtask

    function automatic logic [2*DW-1:0] rand_prod();
        logic [2*DW-1:0] r;
        logic [2*DW-1:0] edges [6];
        edges = '{16'h007F, 16'h0080, 16'hFF7F, 16'hFF80, 16'h8000, 16'h7FFF};
        case ($urandom_range(0, 3))
            0:       r = '0;
            1:       r = 16'($signed(8'($urandom)));
            2:       r = 16'($urandom);
            default: r = edges[$urandom_range(0, 5)];
        endcase
        return r;
    endfunction

    int base;

    initial begin
        rst        = 1'b0;
        prod_in    = '0;
        prod_valid = 1'b0;
        wb_ready   = 1'b0;
        rnd_ready  = 1'b0;
        pulses     = 0;

        @(negedge clk);
        expect_eq("reset_wb_data", wb_data, 0);
        expect_eq("reset_wb_hi", wb_hi, 0);
        expect_eq("reset_flags", {flag_z, flag_n, flag_v}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        wb_ready = 1'b1;

        push(16'h0012);
        wait_drain();
        expect_eq("f0012", {flag_z, flag_n, flag_v}, 3'b000);

        push(16'hFFF6);
        wait_drain();
        expect_eq("fFFF6", {flag_z, flag_n, flag_v}, 3'b010);

        push(16'h0C80);
        wait_drain();
        expect_eq("f0C80", {flag_z, flag_n, flag_v}, 3'b001);

        push(16'h0000);
        wait_drain();
        expect_eq("f0000", {flag_z, flag_n, flag_v}, 3'b100);

        push(16'hFF80);
        wait_drain();
        expect_eq("fFF80", {flag_z, flag_n, flag_v}, 3'b010);

        // Back-pressure during the low byte.
        wb_ready = 1'b0;
        push(16'h1234);
        wait_wb_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_eq("bp_data", wb_data, 8'h34);
            expect_eq("bp_hi", wb_hi, 0);
        end
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        wait_drain();

        // Full FIFO: third product held until the consumer drains.
        wb_ready = 1'b0;
        base     = pulses;
        push(16'h1111);
        push(16'h2222);
        drive(16'h3333);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_eq("full_ready", prod_ready, 0);
        end
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        wait_accept();
        wait_drain();
        expect_eq("full_pulses", pulses - base, 3);

        // Randomized traffic with random back-pressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            prod_valid = 1'($urandom_range(0, 1));
            prod_in    = rand_prod();
            @(posedge clk);
            #1;
        end
        prod_valid = 1'b0;
        rnd_ready  = 1'b0;
        wb_ready   = 1'b1;
        wait_drain();

        // Reset while the high byte of 0xABCD is on the bus.
        wb_ready = 1'b0;
        push(16'hABCD);
        wait_wb_valid();
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        @(negedge clk);
        expect_eq("abcd_hi", wb_hi, 1);
        expect_eq("abcd_data", wb_data, 8'hAB);
        #2;
        rst = 1'b0;
        #1;
        expect_eq("arst_wb_valid", wb_valid, 0);
        expect_eq("arst_wb_data", wb_data, 0);
        expect_eq("arst_wb_hi", wb_hi, 0);
        expect_eq("arst_wb_last", wb_last, 0);
        expect_eq("arst_flags", {flag_z, flag_n, flag_v, flags_valid}, 0);
        expect_eq("arst_prod_ready", prod_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expect_eq("post_rst_idle", wb_valid, 0);
        end
        @(posedge clk);
        #1;
        push(16'h0102);
        wait_drain();
        expect_eq("f0102", {flag_z, flag_n, flag_v}, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
